pcpi_nibble_bridge: RTL and testbench
=====================================

PCPI_NIBBLE_BRIDGE -- requirements
Module: pcpi_nibble_bridge

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on nib_strobe (minimum 2).
REQ-002 Parameter TIMEOUT_CYCLES, default 64: number of non-wait ISSUE cycles before abort (minimum 2).
REQ-003 Port clk, input, 1: the single clock; all state is updated on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port nib_in, input, 4: host nibble; stable while nib_strobe is high.
REQ-006 Port nib_strobe, input, 1: host strobe, asynchronous to clk; each rising edge is one transfer.
REQ-007 Port nib_out, output, 4: result nibble to the host.
REQ-008 Port nib_out_valid, output, 1: nib_out holds a valid result nibble.
REQ-009 Port busy, output, 1: high whenever the state is not IDLE.
REQ-010 Port err, output, 1: sticky timeout flag.
REQ-011 Port pcpi_valid, output, 1: PCPI request.
REQ-012 Port pcpi_insn, output, 32: assembled instruction.
REQ-013 Port pcpi_ready, input, 1: PCPI completion.
REQ-014 Port pcpi_wr, input, 1: PCPI result-write flag, qualified by pcpi_ready.
REQ-015 Port pcpi_wait, input, 1: coprocessor busy; suspends the timeout.
REQ-016 Port pcpi_rd, input, 32: PCPI result, qualified by pcpi_ready.

Function
REQ-017 nib_strobe SHALL pass through SYNC_STAGES flops plus one history flop; rise = synced & ~history.
REQ-018 With SYNC_STAGES=2, the nibble SHALL be captured on the 3rd clk edge counting the first edge that samples nib_strobe high.
REQ-019 The FSM states SHALL be IDLE, LOAD, ISSUE and DRAIN, and the FSM SHALL hold its state when no rise occurs.
REQ-020 IDLE + rise: capture nib_in into pcpi_insn[3:0], clear err, set index to 1, go to LOAD.
REQ-021 LOAD + rise: capture nib_in into pcpi_insn[4*index+3:4*index]; when index is 7, set pcpi_valid to 1 and go to ISSUE; otherwise increment index.
REQ-022 The 3-bit index SHALL wrap from 7 to 0 on leaving LOAD.
REQ-023 pcpi_insn SHALL remain constant from the final capture until the next IDLE capture.
REQ-024 ISSUE: pcpi_valid SHALL stay high until pcpi_ready is sampled high, then fall on that edge.
REQ-025 In ISSUE, if pcpi_ready and pcpi_wr are both high: register pcpi_rd, drive nib_out = rd[3:0] and nib_out_valid = 1, set index to 1, go to DRAIN.
REQ-026 In ISSUE, if pcpi_ready is high and pcpi_wr is low: go to IDLE with no output.
REQ-027 The timeout counter SHALL clear on ISSUE entry and increment in ISSUE only while pcpi_wait is low.
REQ-028 When the timeout count reaches TIMEOUT_CYCLES-1 without pcpi_ready: set pcpi_valid to 0, set err to 1, go to IDLE.
REQ-029 If pcpi_ready and timeout occur in the same cycle, pcpi_ready SHALL win and err SHALL stay 0.
REQ-030 DRAIN + rise with index 1..7: nib_out = rd[4*index+3:4*index], then increment index.
REQ-031 DRAIN + rise with index wrapped to 0: nib_out_valid = 0, go to IDLE.
REQ-032 nib_in SHALL be ignored in DRAIN.
REQ-033 Strobe rises in ISSUE SHALL be discarded, and the history flop SHALL still update so that no rise is replayed later.

Reset
REQ-034 Reset SHALL force state to IDLE, index, timer, pcpi_insn, the result register and nib_out to 0.
REQ-035 Reset SHALL force pcpi_valid, nib_out_valid, busy and err to 0, and clear the sync and history flops.
REQ-036 Reset asserted mid-operation SHALL abandon any partial instruction or pending result, and pcpi_valid SHALL drop asynchronously.

Structure
REQ-037 Package pcpi_bridge_pkg SHALL hold the state enum, NIBBLES=8 and the nibble width of 4.
REQ-038 One sub-module, strobe_sync_edge, SHALL contain the synchronizer chain and rise detector, parameterized by SYNC_STAGES.
REQ-039 pcpi_nibble_bridge SHALL contain the FSM, index, timer, instruction register and result register.

Verification
REQ-040 Load: 8 strobes carrying nibbles 3,2,1,0,F,E,D,C -> pcpi_insn=0xCDEF0123 and pcpi_valid rises the cycle after the 8th capture.
REQ-041 Result: pcpi_ready=1, pcpi_wr=1, pcpi_rd=0x89ABCDEF -> nib_out sequence F,E,D,C,B,A,9,8 over 7 strobes, the 8th strobe clears nib_out_valid, busy=0.
REQ-042 Timeout: no pcpi_ready and pcpi_wait=0 -> pcpi_valid falls after 64 ISSUE cycles, err=1; the next IDLE capture clears err.
REQ-043 Wait extension: pcpi_wait=1 for 200 cycles, then pcpi_ready -> no timeout, err=0, result drained.
REQ-044 Boundaries: pcpi_ready coincident with the timeout cycle -> err=0; strobe held high 100 cycles -> exactly one capture.
REQ-045 Reset after nibble 5 -> all outputs 0; a fresh 8-nibble load then assembles correctly.

Source files
------------

// File: rtl/pcpi_bridge_pkg.sv
// Shared types and constants for the nibble-serial PCPI bridge.
// Covers the FSM state encoding and the nibble slicing helpers.
package pcpi_bridge_pkg;

  localparam int NIBBLES = 8;
  localparam int NIB_W   = 4;
  localparam int WORD_W  = NIBBLES * NIB_W;
  localparam int IDX_W   = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DRAIN = 2'd3
  } bridge_state_e;

  function automatic logic [NIB_W-1:0] nibble_at(input logic [WORD_W-1:0] word,
                                                 input logic [IDX_W-1:0]  idx);
    return word[int'(idx) * NIB_W +: NIB_W];
  endfunction

  function automatic logic [WORD_W-1:0] nibble_put(input logic [WORD_W-1:0] word,
                                                   input logic [IDX_W-1:0]  idx,
                                                   input logic [NIB_W-1:0]  nib);
    logic [WORD_W-1:0] word_o;
    word_o = word;
    word_o[int'(idx) * NIB_W +: NIB_W] = nib;
    return word_o;
  endfunction

endpackage

// File: rtl/strobe_sync_edge.sv
// Brings the asynchronous host strobe into clk and emits a one-cycle rise pulse.
// The history flop always follows the synchronizer, so an ignored rise is never replayed.
module strobe_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic rise_o
);

  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign rise_o = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/pcpi_nibble_bridge.sv
// Assembles a 32-bit PCPI instruction from eight host nibbles, issues it with a
// wait-aware timeout, and returns a written result to the host one nibble per strobe.
module pcpi_nibble_bridge
  import pcpi_bridge_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NIB_W-1:0]  nib_in,
  input  logic              nib_strobe,
  output logic [NIB_W-1:0]  nib_out,
  output logic              nib_out_valid,
  output logic              busy,
  output logic              err,
  output logic              pcpi_valid,
  output logic [WORD_W-1:0] pcpi_insn,
  input  logic              pcpi_ready,
  input  logic              pcpi_wr,
  input  logic              pcpi_wait,
  input  logic [WORD_W-1:0] pcpi_rd
);

  localparam int                TMO      = (TIMEOUT_CYCLES < 2) ? 2 : TIMEOUT_CYCLES;
  localparam int                TMR_W    = $clog2(TMO);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TMO - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NIBBLES - 1);

  logic rise;

  bridge_state_e     state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [TMR_W-1:0]  tmr_q;
  logic [WORD_W-1:0] insn_q;
  logic [WORD_W-1:0] res_q;
  logic [NIB_W-1:0]  nib_out_q;
  logic              nib_vld_q;
  logic              busy_q;
  logic              err_q;
  logic              valid_q;

  strobe_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_strobe_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (nib_strobe),
    .rise_o  (rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      tmr_q     <= '0;
      insn_q    <= '0;
      res_q     <= '0;
      nib_out_q <= '0;
      nib_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            insn_q  <= nibble_put(insn_q, '0, nib_in);
            err_q   <= 1'b0;
            idx_q   <= IDX_ONE;
            busy_q  <= 1'b1;
            state_q <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (rise) begin
            insn_q <= nibble_put(insn_q, idx_q, nib_in);
            idx_q  <= idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
              valid_q <= 1'b1;
              tmr_q   <= '0;
              state_q <= ST_ISSUE;
            end
          end
        end

        // A completion in the same cycle as the last timeout tick takes priority.
        ST_ISSUE: begin
          if (pcpi_ready) begin
            valid_q <= 1'b0;
            if (pcpi_wr) begin
              res_q     <= pcpi_rd;
              nib_out_q <= pcpi_rd[NIB_W-1:0];
              nib_vld_q <= 1'b1;
              idx_q     <= IDX_ONE;
              state_q   <= ST_DRAIN;
            end else begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end else if (!pcpi_wait) begin
            if (tmr_q == TMR_LAST) begin
              valid_q <= 1'b0;
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              tmr_q <= tmr_q + 1'b1;
            end
          end
        end

        ST_DRAIN: begin
          if (rise) begin
            if (idx_q == '0) begin
              nib_vld_q <= 1'b0;
              busy_q    <= 1'b0;
              state_q   <= ST_IDLE;
            end else begin
              nib_out_q <= nibble_at(res_q, idx_q);
              idx_q     <= idx_q + 1'b1;
            end
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign nib_out       = nib_out_q;
  assign nib_out_valid = nib_vld_q;
  assign busy          = busy_q;
  assign err           = err_q;
  assign pcpi_valid    = valid_q;
  assign pcpi_insn     = insn_q;

endmodule

// File: tb/tb_pcpi_nibble_bridge.sv
// Directed bench for the nibble bridge: load, result drain, timeout, wait extension,
// ready-at-timeout, long strobe and mid-operation reset.
module tb_pcpi_nibble_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  nib_in;
  logic        nib_strobe;
  logic [3:0]  nib_out;
  logic        nib_out_valid;
  logic        busy;
  logic        err;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic        pcpi_ready;
  logic        pcpi_wr;
  logic        pcpi_wait;
  logic [31:0] pcpi_rd;

  int checks = 0;
  int errors = 0;

  pcpi_nibble_bridge dut (
    .clk           (clk),
    .rst           (rst),
    .nib_in        (nib_in),
    .nib_strobe    (nib_strobe),
    .nib_out       (nib_out),
    .nib_out_valid (nib_out_valid),
    .busy          (busy),
    .err           (err),
    .pcpi_valid    (pcpi_valid),
    .pcpi_insn     (pcpi_insn),
    .pcpi_ready    (pcpi_ready),
    .pcpi_wr       (pcpi_wr),
    .pcpi_wait     (pcpi_wait),
    .pcpi_rd       (pcpi_rd)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got hang want finish");
    $fatal(1, "watchdog");
  end

  task automatic send_nib(input logic [3:0] v, input int hold);
    @(negedge clk);
    nib_in     = v;
    nib_strobe = 1'b1;
    repeat (hold) @(negedge clk);
    nib_strobe = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Returns #1 after the edge that captures the eighth nibble.
  task automatic load_word(input logic [31:0] w);
    @(negedge clk);
    nib_in     = w[3:0];
    nib_strobe = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL capture_early: busy got %0b want 0", busy); end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL capture_third_edge: busy got %0b want 1", busy); end
    @(negedge clk);
    nib_strobe = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 1; i < 7; i++) send_nib(w[4*i +: 4], 4);
    @(negedge clk);
    nib_in     = w[31:28];
    nib_strobe = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (pcpi_valid !== 1'b0) begin errors++; $display("FAIL valid_early: pcpi_valid got %0b want 0", pcpi_valid); end
    @(posedge clk); #1;
    checks++;
    if (pcpi_valid !== 1'b1) begin errors++; $display("FAIL valid_rise: pcpi_valid got %0b want 1", pcpi_valid); end
    nib_strobe = 1'b0;
  endtask

  task automatic respond(input logic wr, input logic [31:0] rd);
    @(negedge clk);
    pcpi_ready = 1'b1;
    pcpi_wr    = wr;
    pcpi_rd    = rd;
    pcpi_wait  = 1'b0;
    @(posedge clk); #1;
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;
    pcpi_rd    = 32'h0;
  endtask

  task automatic drain_result(input logic [31:0] exp);
    checks++;
    if (nib_out !== exp[3:0] || nib_out_valid !== 1'b1) begin
      errors++; $display("FAIL drain_first: nib_out/valid got %h/%0b want %h/1", nib_out, nib_out_valid, exp[3:0]);
    end
    for (int i = 1; i < 8; i++) begin
      send_nib(4'h6, 4);
      checks++;
      if (nib_out !== exp[4*i +: 4] || nib_out_valid !== 1'b1) begin
        errors++; $display("FAIL drain_nibble_%0d: nib_out/valid got %h/%0b want %h/1", i, nib_out, nib_out_valid, exp[4*i +: 4]);
      end
    end
    send_nib(4'h6, 4);
    checks++;
    if (nib_out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL drain_end: valid/busy got %0b/%0b want 0/0", nib_out_valid, busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pcpi_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", pcpi_valid); end
    checks++;
    if (pcpi_insn !== 32'h0) begin errors++; $display("FAIL reset_insn: got %h want 00000000", pcpi_insn); end
    checks++;
    if (nib_out !== 4'h0) begin errors++; $display("FAIL reset_nib_out: got %h want 0", nib_out); end
    checks++;
    if (nib_out_valid !== 1'b0) begin errors++; $display("FAIL reset_nib_valid: got %0b want 0", nib_out_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", err); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load;
    load_word(32'hCDEF0123);
    checks++;
    if (pcpi_insn !== 32'hCDEF0123) begin errors++; $display("FAIL load_insn: got %h want cdef0123", pcpi_insn); end
    respond(1'b0, 32'h0);
    checks++;
    if (busy !== 1'b0 || nib_out_valid !== 1'b0 || pcpi_valid !== 1'b0) begin
      errors++; $display("FAIL no_write_idle: busy/valid/pcpi_valid got %0b/%0b/%0b want 0/0/0", busy, nib_out_valid, pcpi_valid);
    end
  endtask

  task automatic test_result;
    load_word(32'hCDEF0123);
    send_nib(4'h9, 4);
    checks++;
    if (pcpi_valid !== 1'b1 || busy !== 1'b1 || pcpi_insn !== 32'hCDEF0123 || nib_out_valid !== 1'b0) begin
      errors++; $display("FAIL issue_discard: valid/busy/insn/nvld got %0b/%0b/%h/%0b want 1/1/cdef0123/0", pcpi_valid, busy, pcpi_insn, nib_out_valid);
    end
    respond(1'b1, 32'h89ABCDEF);
    checks++;
    if (pcpi_valid !== 1'b0) begin errors++; $display("FAIL result_valid_fall: got %0b want 0", pcpi_valid); end
    drain_result(32'h89ABCDEF);
  endtask

  task automatic test_timeout;
    int n;
    load_word(32'h12345678);
    n = 0;
    while (pcpi_valid === 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== 64) begin errors++; $display("FAIL timeout_cycles: got %0d want 64", n); end
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL timeout_err: err/busy got %0b/%0b want 1/0", err, busy); end
    load_word(32'h0BADF00D);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %0b want 0", err); end
    checks++;
    if (pcpi_insn !== 32'h0BADF00D) begin errors++; $display("FAIL reload_insn: got %h want 0badf00d", pcpi_insn); end
    respond(1'b0, 32'h0);
  endtask

  task automatic test_wait_extension;
    load_word(32'hA5A5A5A5);
    pcpi_wait = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    checks++;
    if (pcpi_valid !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL wait_hold: valid/err got %0b/%0b want 1/0", pcpi_valid, err);
    end
    respond(1'b1, 32'h13579BDF);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL wait_err: got %0b want 0", err); end
    drain_result(32'h13579BDF);
  endtask

  task automatic test_ready_at_timeout;
    load_word(32'h0F1E2D3C);
    repeat (63) @(posedge clk);
    #1;
    checks++;
    if (pcpi_valid !== 1'b1) begin errors++; $display("FAIL tmo_edge_valid: got %0b want 1", pcpi_valid); end
    pcpi_ready = 1'b1;
    pcpi_wr    = 1'b0;
    @(posedge clk); #1;
    pcpi_ready = 1'b0;
    checks++;
    if (err !== 1'b0 || pcpi_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL ready_wins: err/valid/busy got %0b/%0b/%0b want 0/0/0", err, pcpi_valid, busy);
    end
  endtask

  task automatic test_long_strobe;
    logic [31:0] w;
    w = 32'h76543217;
    send_nib(w[3:0], 100);
    checks++;
    if (busy !== 1'b1 || pcpi_insn[3:0] !== 4'h7) begin
      errors++; $display("FAIL long_strobe_capture: busy/nib0 got %0b/%h want 1/7", busy, pcpi_insn[3:0]);
    end
    for (int i = 1; i < 8; i++) send_nib(w[4*i +: 4], 4);
    checks++;
    if (pcpi_insn !== w || pcpi_valid !== 1'b1) begin
      errors++; $display("FAIL long_strobe_word: insn/valid got %h/%0b want 76543217/1", pcpi_insn, pcpi_valid);
    end
    respond(1'b0, 32'h0);
  endtask

  task automatic test_reset_mid;
    for (int i = 1; i <= 5; i++) send_nib(4'(i), 4);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || pcpi_insn !== 32'h0 || pcpi_valid !== 1'b0 || err !== 1'b0 || nib_out !== 4'h0 || nib_out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid: busy/insn/valid/err/nout/nvld got %0b/%h/%0b/%0b/%h/%0b want all 0", busy, pcpi_insn, pcpi_valid, err, nib_out, nib_out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    load_word(32'hCDEF0123);
    checks++;
    if (pcpi_insn !== 32'hCDEF0123) begin errors++; $display("FAIL reset_reload: got %h want cdef0123", pcpi_insn); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (pcpi_valid !== 1'b0) begin errors++; $display("FAIL reset_async_valid: got %0b want 0", pcpi_valid); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    nib_in     = 4'h0;
    nib_strobe = 1'b0;
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;
    pcpi_wait  = 1'b0;
    pcpi_rd    = 32'h0;
    test_reset;
    test_load;
    test_result;
    test_timeout;
    test_wait_extension;
    test_ready_at_timeout;
    test_long_strobe;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
